// File: rtl/uart_rx_fifo_if.sv
// Bundles the serial input, the CPU-side FIFO controls and the
// status/data outputs of the UART receive front end.
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  RX;
    logic                  RD;
    logic                  CLR;
    logic [7:0]            DOUT;
    logic                  EMPTY;
    logic                  FULL;
    logic [DEPTH_LOG2:0]   COUNT;
    logic                  FERR;
    logic                  OVR;

    modport master (
        output RX, RD, CLR,
        input  DOUT, EMPTY, FULL, COUNT, FERR, OVR
    );

    modport slave (
        input  RX, RD, CLR,
        output DOUT, EMPTY, FULL, COUNT, FERR, OVR
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with mid-bit sampling, feeding a first-word-fall-through
// byte FIFO. Framing and overrun errors are kept as sticky flags.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 216,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic           CLK,
    input  logic           RST,
    uart_rx_fifo_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam int            DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

    logic                  rx_meta;
    logic                  rx_s;
    state_t                state;
    logic [CW-1:0]         cnt;
    logic [2:0]            bit_idx;
    logic [7:0]            shreg;
    logic                  wait_high;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2:0]   wptr;
    logic [DEPTH_LOG2:0]   rptr;
    logic                  ferr_q;
    logic                  ovr_q;

    logic                  stop_hit;
    logic                  push_req;
    logic                  ferr_evt;
    logic                  empty;
    logic                  full;
    logic                  do_pop;
    logic                  do_push;
    logic                  ovr_evt;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.RX;
            rx_s    <= rx_meta;
        end
    end

    // Frame decoder; after a bad stop bit it waits for the line to go high before re-arming
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            wait_high <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_s) begin
                        wait_high <= 1'b0;
                    end else if (!wait_high) begin
                        cnt   <= HALF_LOAD;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (!rx_s) begin
                        cnt     <= BIT_LOAD;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        shreg   <= {rx_s, shreg[7:1]};
                        cnt     <= BIT_LOAD;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state <= IDLE;
                        if (!rx_s) begin
                            wait_high <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stop-sample decode and FIFO arbitration; a pop frees the slot a full-FIFO push needs
    always_comb begin
        stop_hit = (state == STOP) && (cnt == '0);
        push_req = stop_hit && rx_s;
        ferr_evt = stop_hit && !rx_s;
        empty    = (wptr == rptr);
        full     = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                   (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
        do_pop   = bus.RD && !empty;
        do_push  = push_req && (!full || do_pop);
        ovr_evt  = push_req && full && !do_pop;
    end

    // Byte storage; contents are only visible through DOUT while non-empty
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wptr[DEPTH_LOG2-1:0]] <= shreg;
        end
    end

    // Read/write pointers with one extra wrap bit to tell full from empty
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Sticky error flags; a new error in the same cycle as CLR leaves the flag set
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            if (ferr_evt) begin
                ferr_q <= 1'b1;
            end else if (bus.CLR) begin
                ferr_q <= 1'b0;
            end
            if (ovr_evt) begin
                ovr_q <= 1'b1;
            end else if (bus.CLR) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign bus.DOUT  = empty ? 8'h00 : mem[rptr[DEPTH_LOG2-1:0]];
    assign bus.EMPTY = empty;
    assign bus.FULL  = full;
    assign bus.COUNT = wptr - rptr;
    assign bus.FERR  = ferr_q;
    assign bus.OVR   = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: reset, single and back-to-back frames,
// glitch rejection, framing error with break, overflow and async reset.
module tb_uart_rx_fifo;
    localparam int CPB = 108;
    localparam int H   = CPB / 2;
    // Negedge index (from driving the start bit) of the first negedge after the stop-sample edge
    localparam int T   = 3 + H + 9 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic       cap_empty_pre;
    logic       cap_empty_post;
    logic [4:0] cap_count_post;
    logic [7:0] cap_dout_post;

    uart_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst     = 1'b1;
        bus.RX  = 1'b1;
        bus.RD  = 1'b0;
        bus.CLR = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic rd_at_stop);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int i = 0; i < 10 * CPB; i++) begin
            bus.RX = bits[i / CPB];
            if (i == T - 1) begin
                cap_empty_pre = bus.EMPTY;
                bus.RD = rd_at_stop;
            end
            if (i == T) begin
                bus.RD = 1'b0;
                cap_empty_post = bus.EMPTY;
                cap_count_post = bus.COUNT;
                cap_dout_post  = bus.DOUT;
            end
            @(negedge clk);
        end
        bus.RX = 1'b1;
    endtask

    task automatic pop_byte();
        bus.RD = 1'b1;
        @(negedge clk);
        bus.RD = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.EMPTY !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty: got %0b expected 1", bus.EMPTY); end
        checks++; if (bus.FULL !== 1'b0) begin failures++; $display("[TB] FAIL reset_full: got %0b expected 0", bus.FULL); end
        checks++; if (bus.COUNT !== 5'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.COUNT); end
        checks++; if (bus.DOUT !== 8'h00) begin failures++; $display("[TB] FAIL reset_dout: got %h expected 00", bus.DOUT); end
        checks++; if (bus.FERR !== 1'b0) begin failures++; $display("[TB] FAIL reset_ferr: got %0b expected 0", bus.FERR); end
        checks++; if (bus.OVR !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovr: got %0b expected 0", bus.OVR); end
        repeat (10000) @(negedge clk);
        checks++; if (bus.EMPTY !== 1'b1) begin failures++; $display("[TB] FAIL idle_empty: got %0b expected 1", bus.EMPTY); end
        checks++; if (bus.COUNT !== 5'd0) begin failures++; $display("[TB] FAIL idle_count: got %0d expected 0", bus.COUNT); end
    endtask

    task automatic test_single_frame();
        send_frame(8'h52, 1'b1, 1'b0);
        checks++; if (cap_empty_pre !== 1'b1) begin failures++; $display("[TB] FAIL single_empty_before_stop: got %0b expected 1", cap_empty_pre); end
        checks++; if (cap_empty_post !== 1'b0) begin failures++; $display("[TB] FAIL single_empty_after_stop: got %0b expected 0", cap_empty_post); end
        checks++; if (cap_count_post !== 5'd1) begin failures++; $display("[TB] FAIL single_count: got %0d expected 1", cap_count_post); end
        checks++; if (cap_dout_post !== 8'h52) begin failures++; $display("[TB] FAIL single_dout: got %h expected 52", cap_dout_post); end
        pop_byte();
        checks++; if (bus.EMPTY !== 1'b1) begin failures++; $display("[TB] FAIL single_pop_empty: got %0b expected 1", bus.EMPTY); end
        checks++; if (bus.DOUT !== 8'h00) begin failures++; $display("[TB] FAIL single_pop_dout: got %h expected 00", bus.DOUT); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h52, 1'b1, 1'b0);
        send_frame(8'h58, 1'b1, 1'b0);
        checks++; if (bus.COUNT !== 5'd2) begin failures++; $display("[TB] FAIL b2b_count: got %0d expected 2", bus.COUNT); end
        checks++; if (bus.DOUT !== 8'h52) begin failures++; $display("[TB] FAIL b2b_head0: got %h expected 52", bus.DOUT); end
        pop_byte();
        checks++; if (bus.DOUT !== 8'h58) begin failures++; $display("[TB] FAIL b2b_head1: got %h expected 58", bus.DOUT); end
        checks++; if (bus.COUNT !== 5'd1) begin failures++; $display("[TB] FAIL b2b_count1: got %0d expected 1", bus.COUNT); end
        pop_byte();
        checks++; if (bus.EMPTY !== 1'b1) begin failures++; $display("[TB] FAIL b2b_empty: got %0b expected 1", bus.EMPTY); end
        pop_byte();
        checks++; if (bus.COUNT !== 5'd0) begin failures++; $display("[TB] FAIL rd_on_empty_count: got %0d expected 0", bus.COUNT); end
        checks++; if (bus.EMPTY !== 1'b1) begin failures++; $display("[TB] FAIL rd_on_empty_empty: got %0b expected 1", bus.EMPTY); end
    endtask

    task automatic test_glitch();
        bus.RX = 1'b0;
        repeat (50) @(negedge clk);
        bus.RX = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checks++; if (bus.EMPTY !== 1'b1) begin failures++; $display("[TB] FAIL glitch_empty: got %0b expected 1", bus.EMPTY); end
        checks++; if (bus.FERR !== 1'b0) begin failures++; $display("[TB] FAIL glitch_ferr: got %0b expected 0", bus.FERR); end
        send_frame(8'h3C, 1'b1, 1'b0);
        checks++; if (cap_dout_post !== 8'h3C) begin failures++; $display("[TB] FAIL glitch_next_frame: got %h expected 3c", cap_dout_post); end
        pop_byte();
    endtask

    task automatic test_framing();
        send_frame(8'h41, 1'b0, 1'b0);
        bus.RX = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        checks++; if (bus.FERR !== 1'b1) begin failures++; $display("[TB] FAIL framing_ferr: got %0b expected 1", bus.FERR); end
        checks++; if (bus.COUNT !== 5'd0) begin failures++; $display("[TB] FAIL break_count: got %0d expected 0", bus.COUNT); end
        bus.RX = 1'b1;
        repeat (CPB) @(negedge clk);
        send_frame(8'h41, 1'b1, 1'b0);
        checks++; if (bus.DOUT !== 8'h41) begin failures++; $display("[TB] FAIL after_break_dout: got %h expected 41", bus.DOUT); end
        checks++; if (bus.FERR !== 1'b1) begin failures++; $display("[TB] FAIL ferr_sticky: got %0b expected 1", bus.FERR); end
        bus.CLR = 1'b1;
        @(negedge clk);
        bus.CLR = 1'b0;
        checks++; if (bus.FERR !== 1'b0) begin failures++; $display("[TB] FAIL clr_ferr: got %0b expected 0", bus.FERR); end
        pop_byte();
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int b = 0; b < 17; b++) send_frame(8'(b), 1'b1, 1'b0);
        checks++; if (bus.FULL !== 1'b1) begin failures++; $display("[TB] FAIL ovf_full: got %0b expected 1", bus.FULL); end
        checks++; if (bus.COUNT !== 5'd16) begin failures++; $display("[TB] FAIL ovf_count: got %0d expected 16", bus.COUNT); end
        checks++; if (bus.OVR !== 1'b1) begin failures++; $display("[TB] FAIL ovf_ovr: got %0b expected 1", bus.OVR); end
        for (int b = 0; b < 16; b++) begin
            checks++; if (bus.DOUT !== 8'(b)) begin failures++; $display("[TB] FAIL ovf_drain[%0d]: got %h expected %h", b, bus.DOUT, 8'(b)); end
            pop_byte();
        end
        checks++; if (bus.EMPTY !== 1'b1) begin failures++; $display("[TB] FAIL ovf_drained_empty: got %0b expected 1", bus.EMPTY); end
    endtask

    task automatic test_overflow_with_pop();
        apply_reset();
        for (int b = 0; b < 16; b++) send_frame(8'(b), 1'b1, 1'b0);
        send_frame(8'h10, 1'b1, 1'b1);
        checks++; if (bus.OVR !== 1'b0) begin failures++; $display("[TB] FAIL fullpop_ovr: got %0b expected 0", bus.OVR); end
        checks++; if (bus.COUNT !== 5'd16) begin failures++; $display("[TB] FAIL fullpop_count: got %0d expected 16", bus.COUNT); end
        for (int b = 1; b <= 16; b++) begin
            checks++; if (bus.DOUT !== 8'(b)) begin failures++; $display("[TB] FAIL fullpop_drain[%0d]: got %h expected %h", b, bus.DOUT, 8'(b)); end
            pop_byte();
        end
        checks++; if (bus.EMPTY !== 1'b1) begin failures++; $display("[TB] FAIL fullpop_empty: got %0b expected 1", bus.EMPTY); end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] bits;
        apply_reset();
        send_frame(8'hA5, 1'b1, 1'b0);
        bits = {1'b1, 8'h58, 1'b0};
        for (int i = 0; i < 5 * CPB + H; i++) begin
            bus.RX = bits[i / CPB];
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++; if (bus.EMPTY !== 1'b1) begin failures++; $display("[TB] FAIL async_rst_empty: got %0b expected 1", bus.EMPTY); end
        checks++; if (bus.COUNT !== 5'd0) begin failures++; $display("[TB] FAIL async_rst_count: got %0d expected 0", bus.COUNT); end
        checks++; if (bus.DOUT !== 8'h00) begin failures++; $display("[TB] FAIL async_rst_dout: got %h expected 00", bus.DOUT); end
        bus.RX = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h58, 1'b1, 1'b0);
        checks++; if (bus.COUNT !== 5'd1) begin failures++; $display("[TB] FAIL after_rst_count: got %0d expected 1", bus.COUNT); end
        checks++; if (bus.DOUT !== 8'h58) begin failures++; $display("[TB] FAIL after_rst_dout: got %h expected 58", bus.DOUT); end
        pop_byte();
        checks++; if (bus.EMPTY !== 1'b1) begin failures++; $display("[TB] FAIL after_rst_empty: got %0b expected 1", bus.EMPTY); end
    endtask

    // Runs every scenario in order, then reports the totals
    initial begin
        bus.RX  = 1'b1;
        bus.RD  = 1'b0;
        bus.CLR = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_overflow();
        test_overflow_with_pop();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
